// File: rtl/mul_pkg.sv
// Shared types and constants for the 2x2 block multiply responder.
package mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_OUT  = 2'd2
   } state_e;

   // Element index of the 2x2 block; bit 1 is the row, bit 0 the column.
   localparam logic [1:0] EL_UL = 2'd0;
   localparam logic [1:0] EL_UR = 2'd1;
   localparam logic [1:0] EL_DL = 2'd2;
   localparam logic [1:0] EL_DR = 2'd3;

   localparam int unsigned MAC_STEPS = 8;

   // Widest accumulator / result the saturate helper handles.
   localparam int unsigned SAT_AW = 128;
   localparam int unsigned SAT_DW = 64;

   // Clamp a sign-extended accumulator to the signed range of a dw-bit word.
   function automatic logic [SAT_DW-1:0] saturate(input logic signed [SAT_AW-1:0] acc,
                                                  input int unsigned dw);
      logic signed [SAT_AW-1:0] max_v;
      logic signed [SAT_AW-1:0] min_v;
      max_v = (SAT_AW'(1) << (dw - 1)) - SAT_AW'(1);
      min_v = ~max_v;
      if (acc > max_v) begin
         return max_v[SAT_DW-1:0];
      end else if (acc < min_v) begin
         return min_v[SAT_DW-1:0];
      end
      return acc[SAT_DW-1:0];
   endfunction

endpackage

// File: rtl/block_mul_2x2_if.sv
// Block-multiply handshake: A/B block request channel and C tile result channel.
interface block_mul_2x2_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_first;
   logic                  in_last;
   logic [DATA_WIDTH-1:0] a_ul, a_ur, a_dl, a_dr;
   logic [DATA_WIDTH-1:0] b_ul, b_ur, b_dl, b_dr;
   logic                  res_valid;
   logic                  res_ready;
   logic [DATA_WIDTH-1:0] res_ul, res_ur, res_dl, res_dr;

   // Controller side.
   modport master (
      output in_valid, in_first, in_last,
      output a_ul, a_ur, a_dl, a_dr, b_ul, b_ur, b_dl, b_dr,
      output res_ready,
      input  in_ready, res_valid, res_ul, res_ur, res_dl, res_dr
   );

   // Multiplier side.
   modport slave (
      input  in_valid, in_first, in_last,
      input  a_ul, a_ur, a_dl, a_dr, b_ul, b_ur, b_dl, b_dr,
      input  res_ready,
      output in_ready, res_valid, res_ul, res_ur, res_dl, res_dr
   );
endinterface

// File: rtl/mac_unit.sv
// Shared signed MAC: one DATA_WIDTH x DATA_WIDTH product per cycle added into one
// of four ACC_WIDTH accumulators. Exposes the next-state sums so the caller can
// capture a result on the same edge the last product lands.
module mac_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = 72
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr_i,
   input  logic                       en_i,
   input  logic [1:0]                 el_i,
   input  logic [DATA_WIDTH-1:0]      a_i,
   input  logic [DATA_WIDTH-1:0]      b_i,
   output logic [3:0][ACC_WIDTH-1:0]  acc_next_o
);

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext;
   logic [3:0][ACC_WIDTH-1:0]      acc_q, acc_d;

   // Full-width signed product, sign-extended into the accumulator width.
   always_comb begin
      prod     = (2*DATA_WIDTH)'(signed'(a_i)) * (2*DATA_WIDTH)'(signed'(b_i));
      prod_ext = ACC_WIDTH'(prod);
   end

   // Clear on tile start, otherwise add the product into the selected element.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d[el_i] = acc_q[el_i] + prod_ext;
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_next_o = acc_d;

endmodule

// File: rtl/block_mul_2x2.sv
// 2x2 block-multiply responder: accepts A/B blocks, accumulates C += A*B over a
// tile with one shared MAC (8 cycles per block), then presents the C tile.
// Optional: define MUL_SATURATE_EN to clamp results to the signed DATA_WIDTH
// range instead of truncating; accumulators behave identically either way.
module block_mul_2x2
   import mul_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = 72
) (
   input logic            clk,
   input logic            reset,
   block_mul_2x2_if.slave bus
);

   state_e                     state_q, state_d;
   logic [2:0]                 k_q, k_d;
   logic [3:0][DATA_WIDTH-1:0] a_q, a_d;
   logic [3:0][DATA_WIDTH-1:0] b_q, b_d;
   logic                       last_q, last_d;
   logic [3:0][DATA_WIDTH-1:0] res_q, res_d;
   logic                       mac_clr, mac_en;
   logic [3:0][ACC_WIDTH-1:0]  acc_next;

   // Reduce an accumulator to the output word (truncate or saturate).
   function automatic logic [DATA_WIDTH-1:0] to_res(input logic [ACC_WIDTH-1:0] acc);
`ifdef MUL_SATURATE_EN
      logic [SAT_DW-1:0] s;
      s = saturate(SAT_AW'(signed'(acc)), DATA_WIDTH);
      return s[DATA_WIDTH-1:0];
`else
      return acc[DATA_WIDTH-1:0];
`endif
   endfunction

   // k[2:1] picks the C element (row, col), k[0] the inner-product term t:
   // C[r][c] += A[r][t] * B[t][c].
   mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (mac_clr),
      .en_i       (mac_en),
      .el_i       (k_q[2:1]),
      .a_i        (a_q[{k_q[2], k_q[0]}]),
      .b_i        (b_q[{k_q[0], k_q[1]}]),
      .acc_next_o (acc_next)
   );

   // Next-state logic: accept in IDLE, 8 MAC steps, hold result until taken.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      last_d  = last_q;
      res_d   = res_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = {bus.a_dr, bus.a_dl, bus.a_ur, bus.a_ul};
               b_d     = {bus.b_dr, bus.b_dl, bus.b_ur, bus.b_ul};
               last_d  = bus.in_last;
               mac_clr = bus.in_first;
               k_d     = 3'd0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            mac_en = 1'b1;
            k_d    = k_q + 3'd1;
            if (k_q == 3'(MAC_STEPS - 1)) begin
               if (last_q) begin
                  // Capture from next-state sums so the final product is included.
                  for (int e = 0; e < 4; e++) begin
                     res_d[e] = to_res(acc_next[e]);
                  end
                  state_d = S_OUT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_OUT: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, operand and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         k_q     <= 3'd0;
         a_q     <= '0;
         b_q     <= '0;
         last_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         last_q  <= last_d;
         res_q   <= res_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.res_valid = (state_q == S_OUT);
   assign bus.res_ul    = res_q[EL_UL];
   assign bus.res_ur    = res_q[EL_UR];
   assign bus.res_dl    = res_q[EL_DL];
   assign bus.res_dr    = res_q[EL_DR];

endmodule

// File: tb/tb_block_mul_2x2.sv
// Self-checking bench for block_mul_2x2: table of single-block tiles, multi-block
// tiles against a reference model, back-pressure and mid-operation reset.
module tb_block_mul_2x2;

   typedef logic [3:0][31:0] blk_t;  // index 0=ul, 1=ur, 2=dl, 3=dr
   typedef struct {
      blk_t a;
      blk_t b;
      blk_t exp;
   } vec_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;
   blk_t exp_q[$];
   longint mc[4];

   block_mul_2x2_if #(.DATA_WIDTH(32)) bus ();

   block_mul_2x2 #(
      .DATA_WIDTH (32),
      .ACC_WIDTH  (72)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic blk_t mk(input logic [31:0] ul, input logic [31:0] ur,
                               input logic [31:0] dl, input logic [31:0] dr);
      blk_t r;
      r[0] = ul;
      r[1] = ur;
      r[2] = dl;
      r[3] = dr;
      return r;
   endfunction

   function automatic longint sx(input logic [31:0] v);
      return longint'(signed'(v));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_ops(input blk_t a, input blk_t b, input logic first, input logic last);
      bus.a_ul = a[0]; bus.a_ur = a[1]; bus.a_dl = a[2]; bus.a_dr = a[3];
      bus.b_ul = b[0]; bus.b_ur = b[1]; bus.b_dl = b[2]; bus.b_dr = b[3];
      bus.in_first = first;
      bus.in_last  = last;
   endtask

   // Present one block; returns at the falling edge after the accepting edge.
   task automatic send(input blk_t a, input blk_t b, input logic first, input logic last);
      int cnt;
      cnt = 0;
      while (!bus.in_ready && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      if (!bus.in_ready) chk("send_ready_timeout", 32'(bus.in_ready), 32'd1);
      drive_ops(a, b, first, last);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Called right after send() of a last block: latency, data, and optional handshake.
   task automatic get_result(input string name, input bit take);
      int   cnt;
      blk_t e;
      cnt = 0;
      while (!bus.res_valid && cnt < 30) begin
         @(negedge clk);
         cnt++;
      end
      chk({name, "_latency"}, 32'(cnt), 32'd8);
      if (exp_q.size() == 0) begin
         chk({name, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      chk({name, "_ul"}, bus.res_ul, e[0]);
      chk({name, "_ur"}, bus.res_ur, e[1]);
      chk({name, "_dl"}, bus.res_dl, e[2]);
      chk({name, "_dr"}, bus.res_dr, e[3]);
      if (take) begin
         bus.res_ready = 1'b1;
         @(negedge clk);
         chk({name, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
         chk({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
      end
   endtask

   // Reference model: C += A*B over a tile, in 64-bit integers.
   task automatic model_blk(input blk_t a, input blk_t b, input bit first);
      if (first) for (int i = 0; i < 4; i++) mc[i] = 0;
      mc[0] += sx(a[0]) * sx(b[0]) + sx(a[1]) * sx(b[2]);
      mc[1] += sx(a[0]) * sx(b[1]) + sx(a[1]) * sx(b[3]);
      mc[2] += sx(a[2]) * sx(b[0]) + sx(a[3]) * sx(b[2]);
      mc[3] += sx(a[2]) * sx(b[1]) + sx(a[3]) * sx(b[3]);
   endtask

   function automatic logic [31:0] rnd_small();
      return 32'($urandom_range(200) - 100);
   endfunction

   initial begin
      vec_t vecs[6];
      blk_t ident;
      blk_t ones;
      blk_t ra;
      blk_t rb;
      blk_t held;
      int   cnt;
      int   nblk;

      n_cmp  = 0;
      n_fail = 0;
      ident  = mk(1, 0, 0, 1);
      ones   = mk(1, 1, 1, 1);

      vecs[0] = '{a: mk(1, 2, 3, 4), b: mk(5, 6, 7, 8), exp: mk(19, 22, 43, 50)};
      vecs[1] = '{a: mk(-1, 0, 0, -1), b: mk(3, -4, 5, 6),
                  exp: mk(32'hFFFFFFFD, 4, 32'hFFFFFFFB, 32'hFFFFFFFA)};
`ifdef MUL_SATURATE_EN
      vecs[2] = '{a: mk(32'h7FFFFFFF, 0, 0, 0), b: mk(2, 0, 0, 0), exp: mk(32'h7FFFFFFF, 0, 0, 0)};
      vecs[3] = '{a: mk(32'h80000000, 0, 0, 0), b: mk(2, 0, 0, 0), exp: mk(32'h80000000, 0, 0, 0)};
`else
      vecs[2] = '{a: mk(32'h7FFFFFFF, 0, 0, 0), b: mk(2, 0, 0, 0), exp: mk(32'hFFFFFFFE, 0, 0, 0)};
      vecs[3] = '{a: mk(32'h80000000, 0, 0, 0), b: mk(2, 0, 0, 0), exp: mk(32'h00000000, 0, 0, 0)};
`endif
      vecs[4] = '{a: mk(2, 0, 0, 3), b: mk(-7, 1, 4, -2), exp: mk(-14, 2, 12, -6)};
      vecs[5] = '{a: mk(-2, 3, 5, -7), b: mk(4, -1, 6, 8), exp: mk(10, 26, -22, -61)};

      // Reset state
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
      drive_ops('0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_ul", bus.res_ul, 32'd0);
      chk("rst_res_dr", bus.res_dr, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Single-block tiles from the table
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].a, vecs[i].b, 1'b1, 1'b1);
         exp_q.push_back(vecs[i].exp);
         get_result($sformatf("vec%0d", i), 1'b1);
      end

      // Two-block tile: A*I then I*ones; in_ready low for 8 clocks per block
      send(mk(1, 2, 3, 4), ident, 1'b1, 1'b0);
      cnt = 0;
      while (!bus.in_ready && cnt < 30) begin
         @(negedge clk);
         cnt++;
      end
      chk("tile2_busy_len", 32'(cnt), 32'd8);
      send(ident, ones, 1'b0, 1'b1);
      exp_q.push_back(mk(2, 3, 4, 5));
      get_result("tile2", 1'b1);

      // Multi-block tiles against the model
      for (int t = 0; t < 3; t++) begin
         nblk = 2 + t;
         for (int j = 0; j < nblk; j++) begin
            for (int q = 0; q < 4; q++) begin
               ra[q] = rnd_small();
               rb[q] = rnd_small();
            end
            model_blk(ra, rb, j == 0);
            send(ra, rb, j == 0, j == nblk - 1);
         end
         exp_q.push_back(mk(mc[0][31:0], mc[1][31:0], mc[2][31:0], mc[3][31:0]));
         get_result($sformatf("rtile%0d", t), 1'b1);
      end

      // Back-pressure: result held, in_valid pulses ignored
      bus.res_ready = 1'b0;
      send(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b1, 1'b1);
      exp_q.push_back(mk(19, 22, 43, 50));
      get_result("bp", 1'b0);
      held = mk(19, 22, 43, 50);
      for (int c = 0; c < 20; c++) begin
         drive_ops(mk(9, 9, 9, 9), mk(9, 9, 9, 9), 1'b1, 1'b1);
         bus.in_valid = c[0];
         @(negedge clk);
         chk("bp_valid", 32'(bus.res_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_ul", bus.res_ul, held[0]);
         chk("bp_ur", bus.res_ur, held[1]);
         chk("bp_dl", bus.res_dl, held[2]);
         chk("bp_dr", bus.res_dr, held[3]);
      end
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(bus.res_valid), 32'd0);
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      repeat (10) @(negedge clk);
      chk("bp_no_ghost_valid", 32'(bus.res_valid), 32'd0);
      chk("bp_no_ghost_ready", 32'(bus.in_ready), 32'd1);

      // Reset at k=4 of MUL, then a first=0 block accumulates from zero
      send(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("midrst_res_ul", bus.res_ul, 32'd0);
      chk("midrst_res_dr", bus.res_dr, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send(ident, ones, 1'b0, 1'b1);
      exp_q.push_back(mk(1, 1, 1, 1));
      get_result("postrst", 1'b1);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
